// File: rtl/a2d_pkg.sv
// Shared types, constants and command formatting for the ADC128S round-robin scan controller.
package a2d_pkg;

    localparam int NUM_CH_DEF = 8;
    localparam int CH_W       = $clog2(NUM_CH_DEF);
    localparam logic [1:0] ADC_CMD_RD = 2'b00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        WAIT   = 2'd2,
        GAP    = 2'd3
    } scan_st_t;

    // ADC128S control word: channel address sits in bits [13:11].
    function automatic logic [15:0] mk_cmd(input logic [CH_W-1:0] ch);
        return {ADC_CMD_RD, ch, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_scan_ctrl_if.sv
// Start/complete handshake and data words between the scan controller and SPI_mnrch.
interface a2d_scan_ctrl_if;
    logic        snd;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] resp;

    modport master (output snd, output cmd, input done, input resp);
    modport slave  (input snd, input cmd, output done, output resp);
endinterface

// File: rtl/rr_next_sel.sv
// Wrap-around priority search: first set mask bit strictly after cur, falling back to cur itself.
module rr_next_sel #(
    parameter  int NUM_CH = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  nxt
);

    // Scan offsets from farthest to nearest so the nearest hit overwrites; offset NUM_CH is cur itself.
    always_comb begin
        logic [SEL_W-1:0] idx_s;
        nxt   = cur;
        idx_s = cur;
        for (int off = NUM_CH; off >= 1; off--) begin
            idx_s = SEL_W'((int'(cur) + off) % NUM_CH);
            nxt   = mask[idx_s] ? idx_s : nxt;
        end
    end

endmodule

// File: rtl/a2d_scan_ctrl.sv
// Round-robin ADC128S scan scheduler; each response is filed under the channel of the previous command.
module a2d_scan_ctrl
    import a2d_pkg::*;
#(
    parameter  int NUM_CH   = NUM_CH_DEF,
    parameter  int PERIOD_W = 16,
    parameter  int DATA_W   = 12,
    localparam int SEL_W    = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NUM_CH-1:0]        chan_mask,
    input  logic [PERIOD_W-1:0]      gap,
    a2d_scan_ctrl_if.master          spi,
    output logic [NUM_CH*DATA_W-1:0] result,
    output logic [NUM_CH-1:0]        valid,
    output logic                     res_rdy,
    output logic [SEL_W-1:0]         res_ch,
    output logic                     busy
);

    scan_st_t              state_r, state_nxt_s;
    logic [SEL_W-1:0]      cur_ch_r, prev_ch_r, nxt_ch_s;
    logic                  prev_vld_r;
    logic                  done_q_r;
    logic                  done_rise_s;
    logic                  scan_ok_s;
    logic                  gap_zero_s;
    logic [PERIOD_W-1:0]   gap_cnt_r;
    logic                  unused_resp_hi;

    assign done_rise_s    = spi.done & ~done_q_r;
    assign scan_ok_s      = en & (|chan_mask);
    assign gap_zero_s     = (gap_cnt_r == {PERIOD_W{1'b0}});
    assign unused_resp_hi = ^spi.resp[15:DATA_W];

    rr_next_sel #(.NUM_CH(NUM_CH)) u_sel (
        .mask (chan_mask),
        .cur  (cur_ch_r),
        .nxt  (nxt_ch_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = scan_ok_s ? SELECT : IDLE;
            SELECT:  state_nxt_s = WAIT;
            WAIT:    state_nxt_s = done_rise_s ? GAP : WAIT;
            GAP: begin
                if (gap_zero_s) begin
                    state_nxt_s = scan_ok_s ? SELECT : IDLE;
                end else begin
                    state_nxt_s = GAP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath: command issue, response filing, gap timing and pipeline bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spi.snd    <= 1'b0;
            spi.cmd    <= 16'h0000;
            result     <= {(NUM_CH*DATA_W){1'b0}};
            valid      <= {NUM_CH{1'b0}};
            res_rdy    <= 1'b0;
            res_ch     <= {SEL_W{1'b0}};
            busy       <= 1'b0;
            cur_ch_r   <= SEL_W'(NUM_CH - 1);
            prev_ch_r  <= {SEL_W{1'b0}};
            prev_vld_r <= 1'b0;
            gap_cnt_r  <= {PERIOD_W{1'b0}};
            done_q_r   <= 1'b0;
        end else begin
            done_q_r <= spi.done;
            spi.snd  <= 1'b0;
            res_rdy  <= 1'b0;
            case (state_r)
                SELECT: begin
                    spi.cmd  <= mk_cmd(CH_W'(nxt_ch_s));
                    spi.snd  <= 1'b1;
                    busy     <= 1'b1;
                    cur_ch_r <= nxt_ch_s;
                end
                WAIT: begin
                    if (done_rise_s) begin
                        busy <= 1'b0;
                        // The ADC answers for the previous command, so file under prev_ch.
                        if (prev_vld_r) begin
                            result[int'(prev_ch_r)*DATA_W +: DATA_W] <= spi.resp[DATA_W-1:0];
                            valid[prev_ch_r] <= 1'b1;
                            res_rdy          <= 1'b1;
                            res_ch           <= prev_ch_r;
                        end
                        prev_ch_r  <= cur_ch_r;
                        prev_vld_r <= 1'b1;
                        gap_cnt_r  <= gap;
                    end
                end
                GAP: begin
                    if (!gap_zero_s) begin
                        gap_cnt_r <= gap_cnt_r - {{(PERIOD_W-1){1'b0}}, 1'b1};
                    end else if (!scan_ok_s) begin
                        prev_vld_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Directed bench for a2d_scan_ctrl with a SPI_mnrch + ADC128S pipeline model.
module tb_a2d_scan_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  chan_mask;
    logic [15:0] gap;
    logic [95:0] result;
    logic [7:0]  valid;
    logic        res_rdy;
    logic [2:0]  res_ch;
    logic        busy;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          done_cyc = 0;
    logic [11:0] adc_base = 12'h000;
    logic [2:0]  rdy_ch_q[$];
    logic [11:0] rdy_dat_q[$];

    a2d_scan_ctrl_if spi ();

    a2d_scan_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .chan_mask (chan_mask),
        .gap       (gap),
        .spi       (spi),
        .result    (result),
        .valid     (valid),
        .res_rdy   (res_rdy),
        .res_ch    (res_ch),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every table write for later comparison.
    always @(negedge clk) begin
        if (res_rdy) begin
            rdy_ch_q.push_back(res_ch);
            rdy_dat_q.push_back(result[int'(res_ch)*12 +: 12]);
        end
    end

    // SPI_mnrch + ADC128S: done held high until cleared a clock after the next snd;
    // each response carries data for the channel addressed by the previous command.
    initial begin : spi_model
        int         lat;
        logic       active;
        logic       clr_pend;
        logic [2:0] tx_ch;
        logic [2:0] adc_prev;
        spi.done = 1'b0;
        spi.resp = 16'h0000;
        lat = 0; active = 1'b0; clr_pend = 1'b0; tx_ch = 3'd0; adc_prev = 3'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                spi.done = 1'b0;
                active   = 1'b0;
                clr_pend = 1'b0;
            end else begin
                if (clr_pend) begin
                    spi.done = 1'b0;
                    clr_pend = 1'b0;
                end
                if (spi.snd) begin
                    active   = 1'b1;
                    lat      = LAT;
                    tx_ch    = spi.cmd[13:11];
                    clr_pend = 1'b1;
                end else if (active) begin
                    if (lat == 0) begin
                        spi.resp = {4'hA, adc_base + {9'd0, adc_prev}};
                        spi.done = 1'b1;
                        active   = 1'b0;
                        adc_prev = tx_ch;
                        done_cyc = cyc;
                    end else begin
                        lat = lat - 1;
                    end
                end
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rdy_ch_q.delete();
        rdy_dat_q.delete();
    endtask

    task automatic wait_snd(input string tag, output int c);
        bit seen;
        seen = 1'b0;
        c = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (spi.snd) begin
                seen = 1'b1;
                c = cyc;
            end
        end
        if (!seen) chk_eq({tag, "_snd_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_rdy(input string tag, input int n);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (rdy_ch_q.size() >= n) seen = 1'b1;
        end
        if (!seen) chk_eq({tag, "_rdy_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic logic [11:0] slot(input logic [95:0] r, input int ch);
        return r[ch*12 +: 12];
    endfunction

    initial begin : main
        int c1, c2, c3, nsnd;
        chan_mask = 8'h00;
        gap       = 16'd0;
        do_reset();

        // Reset values
        @(negedge clk);
        chk_eq("rst_snd",    {31'd0, spi.snd}, 32'd0);
        chk_eq("rst_cmd",    {16'd0, spi.cmd}, 32'd0);
        chk_eq("rst_result", {31'd0, |result}, 32'd0);
        chk_eq("rst_valid",  {24'd0, valid},   32'd0);
        chk_eq("rst_res_rdy",{31'd0, res_rdy}, 32'd0);
        chk_eq("rst_res_ch", {29'd0, res_ch},  32'd0);
        chk_eq("rst_busy",   {31'd0, busy},    32'd0);

        // 1: single channel, first response discarded
        adc_base = 12'h300; chan_mask = 8'h02; gap = 16'd0; en = 1'b1;
        wait_snd("t1a", c1);
        chk_eq("t1_cmd0", {16'd0, spi.cmd}, 32'h0800);
        chk_eq("t1_busy", {31'd0, busy}, 32'd1);
        wait_snd("t1b", c2);
        chk_eq("t1_cmd1", {16'd0, spi.cmd}, 32'h0800);
        chk_eq("t1_valid_discard", {24'd0, valid}, 32'd0);
        chk_eq("t1_rdy_discard", rdy_ch_q.size(), 32'd0);
        chk_eq("t1_gap0_lat", c2 - done_cyc, 32'd3);
        wait_rdy("t1", 1);
        chk_eq("t1_res_ch", {29'd0, rdy_ch_q[0]}, 32'd1);
        chk_eq("t1_data", {20'd0, rdy_dat_q[0]}, 32'h301);
        chk_eq("t1_valid", {24'd0, valid}, 32'h02);

        // 2: two channels alternate, results follow the previous command
        do_reset();
        adc_base = 12'hC00; chan_mask = 8'h12; gap = 16'd0; en = 1'b1;
        wait_snd("t2a", c1); chk_eq("t2_cmd0", {16'd0, spi.cmd}, 32'h0800);
        wait_snd("t2b", c1); chk_eq("t2_cmd1", {16'd0, spi.cmd}, 32'h2000);
        wait_snd("t2c", c1); chk_eq("t2_cmd2", {16'd0, spi.cmd}, 32'h0800);
        wait_snd("t2d", c1); chk_eq("t2_cmd3", {16'd0, spi.cmd}, 32'h2000);
        wait_rdy("t2", 3);
        chk_eq("t2_ch0", {29'd0, rdy_ch_q[0]}, 32'd1);
        chk_eq("t2_ch1", {29'd0, rdy_ch_q[1]}, 32'd4);
        chk_eq("t2_ch2", {29'd0, rdy_ch_q[2]}, 32'd1);
        chk_eq("t2_dat0", {20'd0, rdy_dat_q[0]}, 32'hC01);
        chk_eq("t2_dat1", {20'd0, rdy_dat_q[1]}, 32'hC04);
        chk_eq("t2_dat2", {20'd0, rdy_dat_q[2]}, 32'hC01);
        chk_eq("t2_valid", {24'd0, valid}, 32'h12);
        chk_eq("t2_tbl_ch4", {20'd0, slot(result, 4)}, 32'hC04);

        // 3: wrap from ch7 to ch0, then empty mask stays idle
        do_reset();
        adc_base = 12'h700; chan_mask = 8'h81; en = 1'b1;
        wait_snd("t3a", c1); chk_eq("t3_cmd0", {16'd0, spi.cmd}, 32'h0000);
        wait_snd("t3b", c1); chk_eq("t3_cmd1", {16'd0, spi.cmd}, 32'h3800);
        wait_snd("t3c", c1); chk_eq("t3_cmd2", {16'd0, spi.cmd}, 32'h0000);
        wait_rdy("t3", 1);
        chk_eq("t3_ch", {29'd0, rdy_ch_q[0]}, 32'd0);
        chk_eq("t3_dat", {20'd0, rdy_dat_q[0]}, 32'h700);
        do_reset();
        chan_mask = 8'h00; en = 1'b1;
        nsnd = 0;
        repeat (50) begin
            @(negedge clk);
            if (spi.snd) nsnd++;
        end
        chk_eq("t3_nomask_snd", nsnd, 32'd0);
        chk_eq("t3_nomask_busy", {31'd0, busy}, 32'd0);

        // 4: gap of 100 idle clocks
        do_reset();
        chan_mask = 8'h02; gap = 16'd100; en = 1'b1;
        wait_snd("t4a", c1);
        wait_snd("t4b", c2);
        chk_eq("t4_gap_lat", c2 - done_cyc, 32'd103);
        chk_eq("t4_spacing0", c2 - c1, 32'd108);
        wait_snd("t4c", c3);
        chk_eq("t4_spacing1", c3 - c2, 32'd108);

        // 5: drop en mid-transfer, then re-enable
        do_reset();
        adc_base = 12'h200; chan_mask = 8'h02; gap = 16'd0; en = 1'b1;
        wait_snd("t5a", c1);
        wait_snd("t5b", c1);
        en = 1'b0;
        wait_rdy("t5", 1);
        chk_eq("t5_ch", {29'd0, rdy_ch_q[0]}, 32'd1);
        chk_eq("t5_dat", {20'd0, rdy_dat_q[0]}, 32'h201);
        nsnd = 0;
        repeat (40) begin
            @(negedge clk);
            if (spi.snd) nsnd++;
        end
        chk_eq("t5_idle_snd", nsnd, 32'd0);
        chk_eq("t5_idle_busy", {31'd0, busy}, 32'd0);
        adc_base = 12'h500;
        rdy_ch_q.delete();
        rdy_dat_q.delete();
        en = 1'b1;
        wait_snd("t5c", c1); chk_eq("t5_re_cmd", {16'd0, spi.cmd}, 32'h0800);
        wait_snd("t5d", c1); chk_eq("t5_re_discard", rdy_ch_q.size(), 32'd0);
        wait_rdy("t5r", 1);
        chk_eq("t5_re_dat", {20'd0, rdy_dat_q[0]}, 32'h501);

        // 6: reset while waiting on a transfer
        do_reset();
        adc_base = 12'h600; chan_mask = 8'h02; gap = 16'd0; en = 1'b1;
        wait_snd("t6a", c1);
        wait_snd("t6b", c1);
        wait_rdy("t6", 1);
        chk_eq("t6_pre_valid", {24'd0, valid}, 32'h02);
        wait_snd("t6c", c1);
        @(negedge clk);
        chk_eq("t6_pre_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_eq("t6_rst_busy",   {31'd0, busy},    32'd0);
        chk_eq("t6_rst_valid",  {24'd0, valid},   32'd0);
        chk_eq("t6_rst_result", {31'd0, |result}, 32'd0);
        chk_eq("t6_rst_cmd",    {16'd0, spi.cmd}, 32'd0);
        chk_eq("t6_rst_snd",    {31'd0, spi.snd}, 32'd0);
        rst_n = 1'b1;
        rdy_ch_q.delete();
        rdy_dat_q.delete();
        wait_snd("t6d", c1); chk_eq("t6_post_cmd", {16'd0, spi.cmd}, 32'h0800);
        wait_snd("t6e", c1);
        wait_rdy("t6r", 1);
        chk_eq("t6_post_ch", {29'd0, rdy_ch_q[0]}, 32'd1);
        chk_eq("t6_post_dat", {20'd0, rdy_dat_q[0]}, 32'h601);
        chk_eq("t6_post_valid", {24'd0, valid}, 32'h02);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
